// File: rtl/kronos_spsram_responder_pkg.sv
// Shared types for the Kronos single-port SRAM responder: FSM encoding,
// latched transaction record and the address range helper.
package kronos_spsram_responder_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } rsp_state_e;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } rsp_src_e;

  typedef struct packed {
    rsp_src_e    src;
    logic        we;
    logic        oor;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } rsp_txn_t;

  // True when the word index addr[31:2] falls outside a 2**memsize word memory.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int memsize);
    return (addr >> (memsize + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/kronos_spsram_responder_if.sv
// Core-side request/grant ports plus SRAM-side port of the responder.
// slave = responder view, master = core + memory view.
interface kronos_spsram_responder_if #(
  parameter int MEMSIZE = 11
);
  logic [31:0]        instr_addr;
  logic               instr_req;
  logic [31:0]        instr_data;
  logic               instr_gnt;

  logic [31:0]        data_addr;
  logic [31:0]        data_wr_data;
  logic [3:0]         data_wr_mask;
  logic               data_rd_req;
  logic               data_wr_req;
  logic [31:0]        data_rd_data;
  logic               data_gnt;

  logic [MEMSIZE-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_wmask;
  logic               mem_en;
  logic               mem_wren;
  logic [31:0]        mem_rdata;

  logic               bus_err;

  modport slave (
    input  instr_addr, instr_req,
    input  data_addr, data_wr_data, data_wr_mask, data_rd_req, data_wr_req,
    input  mem_rdata,
    output instr_data, instr_gnt,
    output data_rd_data, data_gnt,
    output mem_addr, mem_wdata, mem_wmask, mem_en, mem_wren,
    output bus_err
  );

  modport master (
    output instr_addr, instr_req,
    output data_addr, data_wr_data, data_wr_mask, data_rd_req, data_wr_req,
    output mem_rdata,
    input  instr_data, instr_gnt,
    input  data_rd_data, data_gnt,
    input  mem_addr, mem_wdata, mem_wmask, mem_en, mem_wren,
    input  bus_err
  );

endinterface

// File: rtl/kronos_spsram_responder.sv
// Serves the Kronos instruction and data ports from one single-port SRAM,
// data port first, with fixed latency, optional wait states and range check.
//
// state   | meaning
// IDLE    | sample requests, latch winning transaction
// WAIT    | burn WAIT_STATES cycles before the SRAM access
// ACCESS  | SRAM enable/write driven from latched transaction
// RESPOND | one-cycle grant to latched port, read data passed through
module kronos_spsram_responder
  import kronos_spsram_responder_pkg::*;
#(
  parameter int MEMSIZE     = 11,
  parameter int WAIT_STATES = 0
) (
  input  logic                            clk,
  input  logic                            rstz,
  kronos_spsram_responder_if.slave        bus
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

  rsp_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [MEMSIZE-1:0] addr_q, addr_d;
  rsp_txn_t           txn_q, txn_d;

  logic               mem_en_q, mem_en_d;
  logic               mem_wren_q, mem_wren_d;
  logic [MEMSIZE-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_wmask_q, mem_wmask_d;
  logic               instr_gnt_q, instr_gnt_d;
  logic               data_gnt_q, data_gnt_d;
  logic               bus_err_q, bus_err_d;

  logic               accept;
  logic [31:0]        sel_addr;
  rsp_txn_t           sel_txn;
  logic               rd_ok;
  logic               unused_addr_lsb;

  // Arbitration: store, then load, then fetch.
  always_comb begin
    accept        = 1'b0;
    sel_addr      = bus.instr_addr;
    sel_txn       = '0;
    sel_txn.src   = SRC_INSTR;
    if (bus.data_wr_req) begin
      accept        = 1'b1;
      sel_addr      = bus.data_addr;
      sel_txn.src   = SRC_DATA;
      sel_txn.we    = 1'b1;
      sel_txn.mask  = bus.data_wr_mask;
      sel_txn.wdata = bus.data_wr_data;
    end else if (bus.data_rd_req) begin
      accept        = 1'b1;
      sel_addr      = bus.data_addr;
      sel_txn.src   = SRC_DATA;
    end else if (bus.instr_req) begin
      accept        = 1'b1;
    end
    sel_txn.oor = addr_out_of_range(sel_addr, MEMSIZE);
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    txn_d   = txn_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = sel_addr[MEMSIZE+1:2];
          txn_d  = sel_txn;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACCESS:  state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_wren_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    instr_gnt_d = 1'b0;
    data_gnt_d  = 1'b0;
    bus_err_d   = bus_err_q;
    if (state_d == ST_ACCESS && !txn_d.oor) begin
      mem_en_d    = 1'b1;
      mem_wren_d  = txn_d.we;
      mem_addr_d  = addr_d;
      mem_wdata_d = txn_d.wdata;
      mem_wmask_d = txn_d.mask;
    end
    if (state_d == ST_RESPOND) begin
      instr_gnt_d = (txn_q.src == SRC_INSTR);
      data_gnt_d  = (txn_q.src == SRC_DATA);
      bus_err_d   = bus_err_q | txn_q.oor;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      txn_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      instr_gnt_q <= 1'b0;
      data_gnt_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      txn_q       <= txn_d;
      mem_en_q    <= mem_en_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      instr_gnt_q <= instr_gnt_d;
      data_gnt_q  <= data_gnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // SRAM read data is only meaningful for an in-range load/fetch being granted.
  assign rd_ok = (state_q == ST_RESPOND) && !txn_q.we && !txn_q.oor;

  assign bus.instr_data   = (rd_ok && txn_q.src == SRC_INSTR) ? bus.mem_rdata : '0;
  assign bus.data_rd_data = (rd_ok && txn_q.src == SRC_DATA)  ? bus.mem_rdata : '0;
  assign bus.instr_gnt    = instr_gnt_q;
  assign bus.data_gnt     = data_gnt_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_wren     = mem_wren_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wmask    = mem_wmask_q;
  assign bus.bus_err      = bus_err_q;

endmodule

// File: tb/tb_kronos_spsram_responder.sv
// Directed bench for kronos_spsram_responder: one instance without wait states,
// one with three, each backed by a small behavioural SRAM.
module tb_kronos_spsram_responder;
  import kronos_spsram_responder_pkg::*;

  localparam int MEMSIZE = 11;

  logic clk = 1'b0;
  logic rstz;
  always #5 clk = ~clk;

  kronos_spsram_responder_if #(.MEMSIZE(MEMSIZE)) bus0 ();
  kronos_spsram_responder_if #(.MEMSIZE(MEMSIZE)) bus1 ();

  kronos_spsram_responder #(.MEMSIZE(MEMSIZE), .WAIT_STATES(0)) u_dut0 (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus0)
  );

  kronos_spsram_responder #(.MEMSIZE(MEMSIZE), .WAIT_STATES(3)) u_dut1 (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus1)
  );

  logic [31:0]        mem0 [2**MEMSIZE];
  logic [31:0]        mem1 [2**MEMSIZE];
  logic               pre_we;
  logic               pre_sel;
  logic [MEMSIZE-1:0] pre_idx;
  logic [31:0]        pre_val;

  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem0[pre_idx] <= pre_val;
    if (bus0.mem_en) begin
      if (bus0.mem_wren) begin
        for (int b = 0; b < 4; b++)
          if (bus0.mem_wmask[b]) mem0[bus0.mem_addr][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
      end else begin
        bus0.mem_rdata <= mem0[bus0.mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (pre_we && pre_sel) mem1[pre_idx] <= pre_val;
    if (bus1.mem_en) begin
      if (bus1.mem_wren) begin
        for (int b = 0; b < 4; b++)
          if (bus1.mem_wmask[b]) mem1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
      end else begin
        bus1.mem_rdata <= mem1[bus1.mem_addr];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic sel, input int idx, input logic [31:0] val);
    pre_sel = sel;
    pre_idx = idx[MEMSIZE-1:0];
    pre_val = val;
    pre_we  = 1'b1;
    @(posedge clk);
    #1;
    pre_we  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        also_rd;
    int          idx;
    logic [31:0] init;
    logic [31:0] expv;
  } st_vec_t;

  st_vec_t stv [4];

  initial begin
    stv[0] = '{addr: 32'h40, wdata: 32'hAABBCCDD, mask: 4'b0101, also_rd: 1'b0, idx: 16, init: 32'h11223344, expv: 32'h11BB33DD};
    stv[1] = '{addr: 32'h44, wdata: 32'hAABBCCDD, mask: 4'b0100, also_rd: 1'b0, idx: 17, init: 32'h11223344, expv: 32'h11BB3344};
    stv[2] = '{addr: 32'h48, wdata: 32'hFFFFFFFF, mask: 4'b1111, also_rd: 1'b1, idx: 18, init: 32'h00000000, expv: 32'hFFFFFFFF};
    stv[3] = '{addr: 32'h4F, wdata: 32'hAABBCCDD, mask: 4'b1010, also_rd: 1'b0, idx: 19, init: 32'h11223344, expv: 32'hAA22CC44};

    pre_we = 1'b0; pre_sel = 1'b0; pre_idx = '0; pre_val = '0;
    bus0.instr_addr = '0; bus0.instr_req = 1'b0; bus0.data_addr = '0; bus0.data_wr_data = '0;
    bus0.data_wr_mask = '0; bus0.data_rd_req = 1'b0; bus0.data_wr_req = 1'b0;
    bus1.instr_addr = '0; bus1.instr_req = 1'b0; bus1.data_addr = '0; bus1.data_wr_data = '0;
    bus1.data_wr_mask = '0; bus1.data_rd_req = 1'b0; bus1.data_wr_req = 1'b0;
    rstz = 1'b0;

    preload(1'b0, 4, 32'hDEADBEEF);
    preload(1'b0, 5, 32'hCAFEF00D);
    preload(1'b0, 8, 32'h12345678);
    for (int i = 0; i < 4; i++) preload(1'b0, stv[i].idx, stv[i].init);
    for (int i = 0; i < 20; i++) preload(1'b0, 64 + i, 32'hA5000000 | i);
    preload(1'b1, 0, 32'h5A5A5A5A);
    preload(1'b1, 1, 32'h0BADF00D);

    // Reset values
    @(negedge clk);
    chk("rst_instr_gnt", bus0.instr_gnt, 0);
    chk("rst_data_gnt", bus0.data_gnt, 0);
    chk("rst_instr_data", bus0.instr_data, 0);
    chk("rst_data_rd_data", bus0.data_rd_data, 0);
    chk("rst_mem_en", bus0.mem_en, 0);
    chk("rst_mem_wren", bus0.mem_wren, 0);
    chk("rst_mem_addr", bus0.mem_addr, 0);
    chk("rst_mem_wdata", bus0.mem_wdata, 0);
    chk("rst_mem_wmask", bus0.mem_wmask, 0);
    chk("rst_bus_err", bus0.bus_err, 0);
    rstz = 1'b1;

    // Single fetch
    @(posedge clk); #1;
    bus0.instr_addr = 32'h10; bus0.instr_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fetch_mem_en", bus0.mem_en, c == 1);
      chk("fetch_gnt", bus0.instr_gnt, c == 2);
      if (c == 1) chk("fetch_mem_addr", bus0.mem_addr, 4);
      if (c == 2) begin
        chk("fetch_data", bus0.instr_data, 32'hDEADBEEF);
        bus0.instr_req = 1'b0;
      end
    end

    // Collision: load beats fetch, fetch served on the following IDLE
    @(posedge clk); #1;
    bus0.instr_addr = 32'h14; bus0.instr_req = 1'b1;
    bus0.data_addr  = 32'h20; bus0.data_rd_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("coll_data_gnt", bus0.data_gnt, c == 2);
      chk("coll_instr_gnt", bus0.instr_gnt, c == 5);
      if (c == 2) begin
        chk("coll_data_rd", bus0.data_rd_data, 32'h12345678);
        chk("coll_instr_data_idle", bus0.instr_data, 0);
        bus0.data_rd_req = 1'b0;
      end
      if (c == 5) begin
        chk("coll_instr_data", bus0.instr_data, 32'hCAFEF00D);
        bus0.instr_req = 1'b0;
      end
    end

    // Masked stores; the last-but-one also holds a load request
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus0.data_addr = stv[i].addr; bus0.data_wr_data = stv[i].wdata;
      bus0.data_wr_mask = stv[i].mask; bus0.data_wr_req = 1'b1; bus0.data_rd_req = stv[i].also_rd;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("st_data_gnt", bus0.data_gnt, c == 2);
        chk("st_mem_wren", bus0.mem_wren, c == 1);
        if (c == 2) begin
          chk("st_rd_data", bus0.data_rd_data, 0);
          bus0.data_wr_req = 1'b0; bus0.data_rd_req = 1'b0;
        end
      end
      chk("st_mem_word", mem0[stv[i].idx], stv[i].expv);
    end

    // In-range load with three wait states
    @(posedge clk); #1;
    bus1.data_addr = 32'h0; bus1.data_rd_req = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("ws_mem_en", bus1.mem_en, c == 4);
      chk("ws_data_gnt", bus1.data_gnt, c == 5);
      if (c == 5) begin
        chk("ws_rd_data", bus1.data_rd_data, 32'h5A5A5A5A);
        bus1.data_rd_req = 1'b0;
      end
    end

    // Out-of-range load with three wait states
    @(posedge clk); #1;
    bus1.data_addr = 32'h0000_8000; bus1.data_rd_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("oor_mem_en", bus1.mem_en, 0);
      chk("oor_data_gnt", bus1.data_gnt, c == 5);
      chk("oor_bus_err", bus1.bus_err, c >= 5);
      if (c == 5) begin
        chk("oor_rd_data", bus1.data_rd_data, 0);
        bus1.data_rd_req = 1'b0;
      end
    end

    // Reset asserted while in WAIT
    @(posedge clk); #1;
    bus1.instr_addr = 32'h4; bus1.instr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rstz = 1'b0;
    #1;
    chk("mid_rst_bus_err", bus1.bus_err, 0);
    chk("mid_rst_instr_gnt", bus1.instr_gnt, 0);
    chk("mid_rst_mem_en", bus1.mem_en, 0);
    chk("mid_rst_mem_wmask", bus1.mem_wmask, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("in_rst_instr_gnt", bus1.instr_gnt, 0);
      chk("in_rst_mem_en", bus1.mem_en, 0);
    end
    bus1.instr_req = 1'b0;
    rstz = 1'b1;
    @(posedge clk); #1;
    bus1.instr_addr = 32'h4; bus1.instr_req = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("post_rst_mem_en", bus1.mem_en, c == 4);
      chk("post_rst_gnt", bus1.instr_gnt, c == 5);
      if (c == 5) begin
        chk("post_rst_data", bus1.instr_data, 32'h0BADF00D);
        bus1.instr_req = 1'b0;
      end
    end

    // Back-to-back fetches, address advancing every cycle
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      bus0.instr_req  = (c < 20);
      bus0.instr_addr = 32'h100 + 4 * c;
      @(negedge clk);
      chk("b2b_gnt", bus0.instr_gnt, (c % 3) == 2);
      if ((c % 3) == 2) chk("b2b_data", bus0.instr_data, 32'hA5000000 | (c - 2));
    end
    bus0.instr_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
